// File: rtl/wb_arbiter_if.sv
// ---------------------------------------------------------------------------
// wb_arbiter_if
// Purpose : Groups the requester side and the register-file write side of the
//           writeback arbiter into one bundle.
// Signals : req_valid_i  [3:0]         per-requester writeback request
//           req_addr_i   [4*ADDR_W-1:0] destination register, slice k = req k
//           req_data_i   [4*DATA_W-1:0] writeback value, slice k = req k
//           req_status_i [7:0]          2-bit status per requester
//           req_ready_o  [3:0]          combinational grant
//           wrEnA_o/B_o, wrAddrA_o/B_o, wrDataA_o/B_o, wrStatusA_o/B_o
//                                       registered write ports A and B
//           conflict_o                  one-cycle flag after a same-address
//                                       deferral
// Modports: slave  - arbiter side
//           master - requester / register-file side
// ---------------------------------------------------------------------------
interface wb_arbiter_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 16
);
  logic [3:0]          req_valid_i;
  logic [4*ADDR_W-1:0] req_addr_i;
  logic [4*DATA_W-1:0] req_data_i;
  logic [7:0]          req_status_i;
  logic [3:0]          req_ready_o;
  logic                wrEnA_o;
  logic                wrEnB_o;
  logic [ADDR_W-1:0]   wrAddrA_o;
  logic [ADDR_W-1:0]   wrAddrB_o;
  logic [DATA_W-1:0]   wrDataA_o;
  logic [DATA_W-1:0]   wrDataB_o;
  logic [1:0]          wrStatusA_o;
  logic [1:0]          wrStatusB_o;
  logic                conflict_o;

  modport slave (
    input  req_valid_i, req_addr_i, req_data_i, req_status_i,
    output req_ready_o,
    output wrEnA_o, wrEnB_o, wrAddrA_o, wrAddrB_o,
    output wrDataA_o, wrDataB_o, wrStatusA_o, wrStatusB_o,
    output conflict_o
  );

  modport master (
    output req_valid_i, req_addr_i, req_data_i, req_status_i,
    input  req_ready_o,
    input  wrEnA_o, wrEnB_o, wrAddrA_o, wrAddrB_o,
    input  wrDataA_o, wrDataB_o, wrStatusA_o, wrStatusB_o,
    input  conflict_o
  );
endinterface

// File: rtl/wb_arbiter.sv
// ---------------------------------------------------------------------------
// wb_arbiter
// Purpose : Round-robin arbiter that merges four writeback requesters
//           (arithA, arithB, loadStoreA, loadStoreB) onto the two write ports
//           of a register file. Up to two grants per cycle; the second grant
//           must target a different register than the first. Granted writes
//           appear on the write ports one cycle after the grant.
// Ports   : clock_i - single clock, rising edge
//           reset_i - synchronous, active-low reset
//           bus     - wb_arbiter_if.slave (requests, grants, write ports,
//                     conflict flag)
// ---------------------------------------------------------------------------
module wb_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 16
) (
  input  logic         clock_i,
  input  logic         reset_i,
  wb_arbiter_if.slave  bus
);

  // Per-requester views of the flattened request buses
  logic [ADDR_W-1:0] addr_arr [4];
  logic [DATA_W-1:0] data_arr [4];
  logic [1:0]        stat_arr [4];

  for (genvar gi = 0; gi < 4; gi++) begin : g_unpack
    assign addr_arr[gi] = bus.req_addr_i[gi*ADDR_W +: ADDR_W];
    assign data_arr[gi] = bus.req_data_i[gi*DATA_W +: DATA_W];
    assign stat_arr[gi] = bus.req_status_i[gi*2 +: 2];
  end

  // State
  logic [1:0]        ptr_q,        ptr_d;
  logic              wr_en_a_q,    wr_en_a_d;
  logic              wr_en_b_q,    wr_en_b_d;
  logic [ADDR_W-1:0] wr_addr_a_q,  wr_addr_a_d;
  logic [ADDR_W-1:0] wr_addr_b_q,  wr_addr_b_d;
  logic [DATA_W-1:0] wr_data_a_q,  wr_data_a_d;
  logic [DATA_W-1:0] wr_data_b_q,  wr_data_b_d;
  logic [1:0]        wr_stat_a_q,  wr_stat_a_d;
  logic [1:0]        wr_stat_b_q,  wr_stat_b_d;
  logic              conflict_q,   conflict_d;

  // Arbitration results
  logic [3:0] valid_g;
  logic       a_vld, b_vld;
  logic [1:0] a_idx, b_idx;
  logic [1:0] idx;
  logic [3:0] ready;

  // Requests are masked while in reset so nothing is granted then.
  assign valid_g = reset_i ? bus.req_valid_i : 4'b0000;

  always_comb begin
    a_vld      = 1'b0;
    b_vld      = 1'b0;
    a_idx      = 2'd0;
    b_idx      = 2'd0;
    idx        = 2'd0;
    conflict_d = 1'b0;
    // Walk requesters in priority order ptr, ptr+1, ptr+2, ptr+3.
    // Anyone after the port-A winner that targets the same register is
    // deferred; the first remaining one with a different register takes B.
    for (int i = 0; i < 4; i++) begin
      idx = ptr_q + 2'(i);
      if (valid_g[idx]) begin
        if (!a_vld) begin
          a_vld = 1'b1;
          a_idx = idx;
        end else if (addr_arr[idx] == addr_arr[a_idx]) begin
          conflict_d = 1'b1;
        end else if (!b_vld) begin
          b_vld = 1'b1;
          b_idx = idx;
        end
      end
    end
  end

  always_comb begin
    ready = 4'b0000;
    if (a_vld) ready[a_idx] = 1'b1;
    if (b_vld) ready[b_idx] = 1'b1;
  end

  always_comb begin
    ptr_d       = ptr_q;
    wr_en_a_d   = a_vld;
    wr_en_b_d   = b_vld;
    wr_addr_a_d = wr_addr_a_q;
    wr_data_a_d = wr_data_a_q;
    wr_stat_a_d = wr_stat_a_q;
    wr_addr_b_d = wr_addr_b_q;
    wr_data_b_d = wr_data_b_q;
    wr_stat_b_d = wr_stat_b_q;
    if (a_vld) begin
      wr_addr_a_d = addr_arr[a_idx];
      wr_data_a_d = data_arr[a_idx];
      wr_stat_a_d = stat_arr[a_idx];
      // B is always later than A in priority order, so it is the last grant.
      ptr_d       = (b_vld ? b_idx : a_idx) + 2'd1;
    end
    if (b_vld) begin
      wr_addr_b_d = addr_arr[b_idx];
      wr_data_b_d = data_arr[b_idx];
      wr_stat_b_d = stat_arr[b_idx];
    end
  end

  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      ptr_q       <= 2'd0;
      wr_en_a_q   <= 1'b0;
      wr_en_b_q   <= 1'b0;
      wr_addr_a_q <= '0;
      wr_addr_b_q <= '0;
      wr_data_a_q <= '0;
      wr_data_b_q <= '0;
      wr_stat_a_q <= 2'd0;
      wr_stat_b_q <= 2'd0;
      conflict_q  <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      wr_en_a_q   <= wr_en_a_d;
      wr_en_b_q   <= wr_en_b_d;
      wr_addr_a_q <= wr_addr_a_d;
      wr_addr_b_q <= wr_addr_b_d;
      wr_data_a_q <= wr_data_a_d;
      wr_data_b_q <= wr_data_b_d;
      wr_stat_a_q <= wr_stat_a_d;
      wr_stat_b_q <= wr_stat_b_d;
      conflict_q  <= conflict_d;
    end
  end

  assign bus.req_ready_o = ready;
  assign bus.wrEnA_o     = wr_en_a_q;
  assign bus.wrEnB_o     = wr_en_b_q;
  assign bus.wrAddrA_o   = wr_addr_a_q;
  assign bus.wrAddrB_o   = wr_addr_b_q;
  assign bus.wrDataA_o   = wr_data_a_q;
  assign bus.wrDataB_o   = wr_data_b_q;
  assign bus.wrStatusA_o = wr_stat_a_q;
  assign bus.wrStatusB_o = wr_stat_b_q;
  assign bus.conflict_o  = conflict_q;

endmodule
